// File: rtl/petris_vga_pkg.sv
// Shared VGA/frame-buffer definitions: geometry defaults, colour encoding,
// command opcodes and the block-writer state encoding.
package petris_vga_pkg;

   localparam int FB_WIDTH_DEF  = 800;
   localparam int FB_HEIGHT_DEF = 525;

   // Pixel word is {B,G,R}
   localparam int R_BIT = 0;
   localparam int G_BIT = 1;
   localparam int B_BIT = 2;

   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] RED     = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] YELLOW  = 3'b011;
   localparam logic [2:0] BLUE    = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] CYAN    = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

   localparam logic OP_DRAW  = 1'b0;
   localparam logic OP_CLEAR = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      CLEAR = 2'd2
   } fb_state_e;

   function automatic logic in_frame(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] w, input logic [11:0] h);
      return (x < w) && (y < h);
   endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Nested x/y raster counter with runtime limits. Offsets hold the position
// that will be emitted on the next step; last rises once the final position
// has been stepped past, and stays high until the next start.
module fb_raster_counter (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       advance,
   input  logic [9:0] x_limit,
   input  logic [9:0] y_limit,
   output logic [9:0] x_off,
   output logic [9:0] y_off,
   output logic       last
);

   logic [9:0] x_off_r;
   logic [9:0] y_off_r;
   logic       last_r;
   logic [9:0] cur_x_s;
   logic [9:0] cur_y_s;
   logic       x_wrap_s;
   logic       at_end_s;

   // A start restarts the scan from the origin position
   always_comb begin
      cur_x_s = x_off_r;
      cur_y_s = y_off_r;
      if (start) begin
         cur_x_s = 10'd0;
         cur_y_s = 10'd0;
      end else begin
         cur_x_s = x_off_r;
         cur_y_s = y_off_r;
      end
      x_wrap_s = (cur_x_s == x_limit);
      at_end_s = x_wrap_s && (cur_y_s == y_limit);
   end

   // Step the offsets in raster order, flagging completion at the end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_off_r <= 10'd0;
         y_off_r <= 10'd0;
         last_r  <= 1'b0;
      end else if (start || advance) begin
         if (at_end_s) begin
            x_off_r <= 10'd0;
            y_off_r <= 10'd0;
            last_r  <= 1'b1;
         end else if (x_wrap_s) begin
            x_off_r <= 10'd0;
            y_off_r <= cur_y_s + 10'd1;
            last_r  <= 1'b0;
         end else begin
            x_off_r <= cur_x_s + 10'd1;
            y_off_r <= cur_y_s;
            last_r  <= 1'b0;
         end
      end else begin
         x_off_r <= x_off_r;
         y_off_r <= y_off_r;
         last_r  <= last_r;
      end
   end

   assign x_off = x_off_r;
   assign y_off = y_off_r;
   assign last  = last_r;

endmodule

// File: rtl/fb_block_writer.sv
// Command-driven frame-buffer writer: fills one game cell or clears the whole
// buffer, emitting one registered pixel write per clock with edge clipping.
module fb_block_writer
   import petris_vga_pkg::*;
#(
   parameter int FB_WIDTH   = FB_WIDTH_DEF,
   parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
   parameter int BLOCK_SIZE = 16,
   parameter int ORIGIN_X   = 0,
   parameter int ORIGIN_Y   = 0
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_op,
   input  logic [5:0] cmd_col,
   input  logic [5:0] cmd_row,
   input  logic [2:0] cmd_color,
   output logic       fb_we,
   output logic [9:0] fb_x,
   output logic [9:0] fb_y,
   output logic [2:0] fb_pixel,
   output logic       busy
);

   localparam logic [9:0]  BLK_LIMIT = 10'(BLOCK_SIZE - 1);
   localparam logic [9:0]  FBX_LIMIT = 10'(FB_WIDTH - 1);
   localparam logic [9:0]  FBY_LIMIT = 10'(FB_HEIGHT - 1);
   localparam logic [11:0] FB_W12    = 12'(FB_WIDTH);
   localparam logic [11:0] FB_H12    = 12'(FB_HEIGHT);
   localparam logic [11:0] ORG_X12   = 12'(ORIGIN_X);
   localparam logic [11:0] ORG_Y12   = 12'(ORIGIN_Y);
   localparam logic [11:0] BLK12     = 12'(BLOCK_SIZE);

   fb_state_e  state_r;
   logic       op_r;
   logic [11:0] base_x_r;
   logic [11:0] base_y_r;

   logic       op_sel_s;
   logic       start_s;
   logic       advance_s;
   logic       scan_last_s;
   logic [9:0] x_limit_s;
   logic [9:0] y_limit_s;
   logic [9:0] x_off_s;
   logic [9:0] y_off_s;
   logic [11:0] cmd_bx_s;
   logic [11:0] cmd_by_s;
   logic [11:0] emit_x_s;
   logic [11:0] emit_y_s;
   logic       emit_in_s;

   assign cmd_ready = (state_r == IDLE);
   assign start_s   = cmd_valid && (state_r == IDLE);
   assign advance_s = (state_r != IDLE) && !scan_last_s;

   // Scan limits follow the incoming op at accept, the latched op afterwards
   always_comb begin
      op_sel_s  = op_r;
      x_limit_s = BLK_LIMIT;
      y_limit_s = BLK_LIMIT;
      if (state_r == IDLE) begin
         op_sel_s = cmd_op;
      end else begin
         op_sel_s = op_r;
      end
      if (op_sel_s == OP_CLEAR) begin
         x_limit_s = FBX_LIMIT;
         y_limit_s = FBY_LIMIT;
      end else begin
         x_limit_s = BLK_LIMIT;
         y_limit_s = BLK_LIMIT;
      end
   end

   // Base of the incoming command and the next pixel position to emit
   always_comb begin
      cmd_bx_s = 12'd0;
      cmd_by_s = 12'd0;
      emit_x_s = 12'd0;
      emit_y_s = 12'd0;
      if (cmd_op == OP_CLEAR) begin
         cmd_bx_s = 12'd0;
         cmd_by_s = 12'd0;
      end else begin
         cmd_bx_s = ORG_X12 + (12'(cmd_col) * BLK12);
         cmd_by_s = ORG_Y12 + (12'(cmd_row) * BLK12);
      end
      if (state_r == IDLE) begin
         emit_x_s = cmd_bx_s;
         emit_y_s = cmd_by_s;
      end else begin
         emit_x_s = base_x_r + {2'b00, x_off_s};
         emit_y_s = base_y_r + {2'b00, y_off_s};
      end
      emit_in_s = in_frame(emit_x_s, emit_y_s, FB_W12, FB_H12);
   end

   fb_raster_counter u_raster (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start_s),
      .advance (advance_s),
      .x_limit (x_limit_s),
      .y_limit (y_limit_s),
      .x_off   (x_off_s),
      .y_off   (y_off_s),
      .last    (scan_last_s)
   );

   // Command FSM with registered pixel-write outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         op_r     <= OP_DRAW;
         base_x_r <= 12'd0;
         base_y_r <= 12'd0;
         fb_we    <= 1'b0;
         fb_x     <= 10'd0;
         fb_y     <= 10'd0;
         fb_pixel <= 3'b000;
         busy     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_op == OP_CLEAR) begin
                     state_r <= CLEAR;
                  end else begin
                     state_r <= DRAW;
                  end
                  op_r     <= cmd_op;
                  base_x_r <= cmd_bx_s;
                  base_y_r <= cmd_by_s;
                  fb_we    <= emit_in_s;
                  fb_x     <= emit_x_s[9:0];
                  fb_y     <= emit_y_s[9:0];
                  fb_pixel <= cmd_color;
                  busy     <= 1'b1;
               end else begin
                  fb_we <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            DRAW, CLEAR: begin
               if (scan_last_s) begin
                  state_r <= IDLE;
                  fb_we   <= 1'b0;
                  busy    <= 1'b0;
               end else begin
                  fb_we <= emit_in_s;
                  fb_x  <= emit_x_s[9:0];
                  fb_y  <= emit_y_s[9:0];
                  busy  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               fb_we   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_block_writer.sv
// Self-checking bench for fb_block_writer: a default-geometry instance plus a
// small-geometry instance so a full CLEAR stays short.
module tb_fb_block_writer;

   logic       clock;
   logic       reset_n;
   logic       valid_a;
   logic       valid_b;
   logic       cmd_op;
   logic [5:0] cmd_col;
   logic [5:0] cmd_row;
   logic [2:0] cmd_color;

   logic       ready_a, we_a, busy_a;
   logic [9:0] x_a, y_a;
   logic [2:0] pix_a;
   logic       ready_b, we_b, busy_b;
   logic [9:0] x_b, y_b;
   logic [2:0] pix_b;

   logic       sel_m;
   logic       ready_m, we_m, busy_m;
   logic [9:0] x_m, y_m;
   logic [2:0] pix_m;

   int checks;
   int failures;

   fb_block_writer u_dut_a (
      .clock(clock), .reset_n(reset_n), .cmd_valid(valid_a), .cmd_ready(ready_a),
      .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_color(cmd_color),
      .fb_we(we_a), .fb_x(x_a), .fb_y(y_a), .fb_pixel(pix_a), .busy(busy_a)
   );

   fb_block_writer #(.FB_WIDTH(40), .FB_HEIGHT(21), .BLOCK_SIZE(4), .ORIGIN_X(2), .ORIGIN_Y(3)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .cmd_valid(valid_b), .cmd_ready(ready_b),
      .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_color(cmd_color),
      .fb_we(we_b), .fb_x(x_b), .fb_y(y_b), .fb_pixel(pix_b), .busy(busy_b)
   );

   assign ready_m = sel_m ? ready_b : ready_a;
   assign we_m    = sel_m ? we_b    : we_a;
   assign busy_m  = sel_m ? busy_b  : busy_a;
   assign x_m     = sel_m ? x_b     : x_a;
   assign y_m     = sel_m ? y_b     : y_a;
   assign pix_m   = sel_m ? pix_b   : pix_a;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Issue one command and follow it cycle by cycle against a raster model
   task automatic run_cmd(input string name, input logic sel, input logic op,
                          input logic [5:0] col, input logic [5:0] row, input logic [2:0] color,
                          input int exp_writes, input int exp_cycles);
      int w, h, bs, ox, oy, p, xs, bx, by, x, y, writes, cyc, errs;
      logic ew;
      w  = sel ? 40 : 800;
      h  = sel ? 21 : 525;
      bs = sel ? 4  : 16;
      ox = sel ? 2  : 0;
      oy = sel ? 3  : 0;
      p  = op ? w * h : bs * bs;
      xs = op ? w : bs;
      bx = op ? 0 : ox + int'(col) * bs;
      by = op ? 0 : oy + int'(row) * bs;
      writes = 0; cyc = 0; errs = 0;
      @(negedge clock);
      sel_m = sel;
      #1;
      check({name, "_ready_pre"}, 32'(ready_m), 32'd1);
      cmd_op = op; cmd_col = col; cmd_row = row; cmd_color = color;
      if (sel) valid_b = 1'b1; else valid_a = 1'b1;
      @(negedge clock);
      valid_a = 1'b0; valid_b = 1'b0;
      for (int k = 0; k < p; k++) begin
         x = bx + (k % xs);
         y = by + (k / xs);
         ew = (x < w) && (y < h);
         if (busy_m !== 1'b1 || ready_m !== 1'b0 || we_m !== ew ||
             x_m !== x[9:0] || y_m !== y[9:0] || pix_m !== color) errs++;
         if (we_m === 1'b1) writes++;
         if (busy_m === 1'b1) cyc++;
         @(negedge clock);
      end
      check({name, "_writes"}, 32'(writes), 32'(exp_writes));
      check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      check({name, "_seq_errs"}, 32'(errs), 32'd0);
      check({name, "_idle_after"}, {29'd0, ready_m, busy_m, we_m}, {29'd0, 1'b1, 1'b0, 1'b0});
   endtask

   typedef struct {
      string      name;
      logic       sel;
      logic       op;
      logic [5:0] col;
      logic [5:0] row;
      logic [2:0] color;
      int         exp_writes;
      int         exp_cycles;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int wr, stray, errs;
      logic hit;
      checks = 0; failures = 0;
      reset_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; sel_m = 1'b0;
      cmd_op = 1'b0; cmd_col = 6'd0; cmd_row = 6'd0; cmd_color = 3'b000;

      vecs[0] = '{"draw_c0r0",   1'b0, 1'b0, 6'd0,  6'd0,  3'b100, 256, 256};
      vecs[1] = '{"draw_c49",    1'b0, 1'b0, 6'd49, 6'd0,  3'b010, 256, 256};
      vecs[2] = '{"draw_c50",    1'b0, 1'b0, 6'd50, 6'd0,  3'b111, 0,   256};
      vecs[3] = '{"draw_r32",    1'b0, 1'b0, 6'd0,  6'd32, 3'b011, 208, 256};
      vecs[4] = '{"draw_c3r5",   1'b0, 1'b0, 6'd3,  6'd5,  3'b101, 256, 256};
      vecs[5] = '{"small_clr0",  1'b1, 1'b1, 6'd5,  6'd7,  3'b000, 840, 840};
      vecs[6] = '{"small_corner",1'b1, 1'b0, 6'd9,  6'd4,  3'b001, 4,   16};
      vecs[7] = '{"small_c0r0",  1'b1, 1'b0, 6'd0,  6'd0,  3'b110, 16,  16};
      vecs[8] = '{"small_clr7",  1'b1, 1'b1, 6'd0,  6'd0,  3'b111, 840, 840};

      repeat (3) @(negedge clock);
      check("rst_we",    32'(we_a),    32'd0);
      check("rst_x",     32'(x_a),     32'd0);
      check("rst_y",     32'(y_a),     32'd0);
      check("rst_pixel", 32'(pix_a),   32'd0);
      check("rst_busy",  32'(busy_a),  32'd0);
      check("rst_ready", 32'(ready_a), 32'd1);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         run_cmd(vecs[i].name, vecs[i].sel, vecs[i].op, vecs[i].col, vecs[i].row,
                 vecs[i].color, vecs[i].exp_writes, vecs[i].exp_cycles);
      end

      // Back-to-back: second DRAW held valid during the first
      sel_m = 1'b0;
      @(negedge clock);
      cmd_op = 1'b0; cmd_col = 6'd1; cmd_row = 6'd1; cmd_color = 3'b001; valid_a = 1'b1;
      @(negedge clock);
      cmd_col = 6'd2; cmd_row = 6'd2; cmd_color = 3'b110;
      errs = 0;
      for (int k = 0; k < 256; k++) begin
         if (we_a !== 1'b1 || busy_a !== 1'b1 || x_a !== 10'(16 + k % 16) ||
             y_a !== 10'(16 + k / 16) || pix_a !== 3'b001) errs++;
         @(negedge clock);
      end
      check("b2b_first_seq", 32'(errs), 32'd0);
      check("b2b_gap", {29'd0, we_a, busy_a, ready_a}, {29'd0, 1'b0, 1'b0, 1'b1});
      @(negedge clock);
      valid_a = 1'b0;
      check("b2b_second_first", {10'd0, we_a, busy_a, x_a, y_a, pix_a},
            {10'd0, 1'b1, 1'b1, 10'd32, 10'd32, 3'b110});
      wr = 1;
      for (int k = 1; k < 300 && busy_a === 1'b1; k++) begin
         @(negedge clock);
         if (we_a === 1'b1) wr++;
      end
      check("b2b_second_writes", 32'(wr), 32'd256);
      check("b2b_idle", {30'd0, busy_a, ready_a}, {30'd0, 1'b0, 1'b1});

      // Reset mid-draw after the 100th write
      @(negedge clock);
      cmd_op = 1'b0; cmd_col = 6'd2; cmd_row = 6'd1; cmd_color = 3'b001; valid_a = 1'b1;
      @(negedge clock);
      valid_a = 1'b0;
      wr = 0; hit = 1'b0;
      for (int k = 0; k < 300 && !hit; k++) begin
         if (we_a === 1'b1) wr++;
         if (wr == 100) hit = 1'b1;
         else @(negedge clock);
      end
      check("rst_mid_reached100", 32'(hit), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", {15'd0, we_a, busy_a, x_a, y_a, pix_a, ready_a},
            {15'd0, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000, 1'b1});
      @(negedge clock);
      reset_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock);
         if (we_a !== 1'b0 || busy_a !== 1'b0) stray++;
      end
      check("rst_mid_no_writes", 32'(stray), 32'd0);
      run_cmd("after_rst", 1'b0, 1'b0, 6'd4, 6'd6, 3'b010, 256, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
